// File: rtl/seat_arb.sv
// ---------------------------------------------------------------------------
// seat_arb
//   Single-port sequencer for the seat table (timestamp + 2-bit state per
//   seat). It is the only master of the table port. It arbitrates kiosk
//   requesters round-robin, rejects an occupy request on an already occupied
//   seat, and runs a periodic timeout sweep. The sweep frees reserved seats
//   whose elapsed time exceeds limit_time.
//
//   Optional feature macro: SEAT_ARB_STATS_EN
//     Adds saturating counters stat_reject / stat_expire.
//
// Ports
//   clk_arb, rst_arb       clock (rising edge), async active-low reset
//   req/req_seat/req_state per-requester level request, seat index, new state
//   ack, rsp_reject        1-cycle completion pulse and its reject flag
//   now_time, limit_time   current time and away timeout (minutes, wrapping)
//   sweep_tick, sweep_busy sweep request pulse and sweep-in-progress flag
//   mem_*                  table port; read data is valid 1 cycle after mem_addr
//   stat_reject/expire     (SEAT_ARB_STATS_EN only) event counters
// ---------------------------------------------------------------------------
module seat_arb #(
    parameter int N_REQ  = 4,
    parameter int SEAT_W = 5,
    parameter int TIME_W = 11
) (
    input  logic                    clk_arb,
    input  logic                    rst_arb,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*SEAT_W-1:0] req_seat,
    input  logic [N_REQ*2-1:0]      req_state,
    output logic [N_REQ-1:0]        ack,
    output logic                    rsp_reject,
    input  logic [TIME_W-1:0]       now_time,
    input  logic [TIME_W-1:0]       limit_time,
    input  logic                    sweep_tick,
    output logic                    sweep_busy,
    output logic [SEAT_W-1:0]       mem_addr,
    output logic                    mem_we,
    output logic [TIME_W-1:0]       mem_wtime,
    output logic [1:0]              mem_wstate,
    input  logic [TIME_W-1:0]       mem_rtime,
    input  logic [1:0]              mem_rstate
`ifdef SEAT_ARB_STATS_EN
    ,
    output logic [15:0]             stat_reject,
    output logic [15:0]             stat_expire
`endif
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [2:0] {
        IDLE,
        R_CHK,
        R_ACK,
        S_RD,
        S_CHK
    } state_t;

    state_t              state, state_d;
    logic [PTR_W-1:0]    rr_ptr;
    logic [PTR_W-1:0]    gnt_q;
    logic [SEAT_W-1:0]   seat_q;
    logic [1:0]          wstate_q;
    logic                reject_q;
    logic [SEAT_W-1:0]   idx;
    logic                sweep_pend;

    logic [SEAT_W-1:0]   seat_arr  [N_REQ];
    logic [1:0]          state_arr [N_REQ];
    logic                gnt_any;
    logic [PTR_W-1:0]    gnt_idx;
    logic [PTR_W-1:0]    cand;
    logic                grant_take;
    logic                start_sweep;
    logic                reject_d;
    logic                expire;
    logic                sweeping;
    logic [TIME_W-1:0]   elapsed;

    // Unpack the flat request buses so they can be indexed by grant number.
    always_comb begin
        for (int unsigned i = 0; i < N_REQ; i++) begin
            seat_arr[i]  = req_seat[i*SEAT_W +: SEAT_W];
            state_arr[i] = req_state[i*2 +: 2];
        end
    end

    // First requester at or after rr_ptr, wrapping.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            cand = PTR_W'((int'(rr_ptr) + int'(k)) % N_REQ);
            if (!gnt_any && req[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    // Modular subtract handles timestamp wrap.
    always_comb begin
        elapsed = now_time - mem_rtime;
    end

    assign sweeping = (state == S_RD) || (state == S_CHK);
    assign expire   = (state == S_CHK) && (mem_rstate == 2'd1) && (elapsed > limit_time);
    assign reject_d = (mem_rstate == 2'd3) && (wstate_q == 2'd3);

    // mem_addr is driven combinationally in IDLE so the table read lands in
    // R_CHK; in every other state it comes from the latched seat/index.
    always_comb begin
        state_d     = state;
        mem_addr    = seat_q;
        mem_we      = 1'b0;
        mem_wtime   = now_time;
        mem_wstate  = wstate_q;
        ack         = '0;
        rsp_reject  = 1'b0;
        sweep_busy  = 1'b0;
        grant_take  = 1'b0;
        start_sweep = 1'b0;
        case (state)
            IDLE: begin
                if (sweep_pend) begin
                    start_sweep = 1'b1;
                    state_d     = S_RD;
                end else if (gnt_any) begin
                    grant_take = 1'b1;
                    mem_addr   = seat_arr[gnt_idx];
                    state_d    = R_CHK;
                end
            end
            R_CHK: begin
                if (!reject_d) begin
                    mem_we     = 1'b1;
                    mem_wtime  = now_time;
                    mem_wstate = wstate_q;
                end
                state_d = R_ACK;
            end
            R_ACK: begin
                ack[gnt_q] = 1'b1;
                rsp_reject = reject_q;
                state_d    = IDLE;
            end
            S_RD: begin
                sweep_busy = 1'b1;
                mem_addr   = idx;
                state_d    = S_CHK;
            end
            S_CHK: begin
                sweep_busy = 1'b1;
                mem_addr   = idx;
                if (expire) begin
                    // Expired seat goes free; its stored time is kept.
                    mem_we     = 1'b1;
                    mem_wtime  = mem_rtime;
                    mem_wstate = 2'd0;
                end
                state_d = (idx == '1) ? IDLE : S_RD;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_arb or negedge rst_arb) begin
        if (!rst_arb) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            gnt_q      <= '0;
            seat_q     <= '0;
            wstate_q   <= '0;
            reject_q   <= 1'b0;
            idx        <= '0;
            sweep_pend <= 1'b0;
        end else begin
            state <= state_d;
            if (grant_take) begin
                gnt_q    <= gnt_idx;
                seat_q   <= seat_arr[gnt_idx];
                wstate_q <= state_arr[gnt_idx];
            end
            if (state == R_CHK) begin
                reject_q <= reject_d;
            end
            if (state == R_ACK) begin
                rr_ptr <= (gnt_q == PTR_W'(N_REQ - 1)) ? '0 : gnt_q + 1'b1;
            end
            if (start_sweep) begin
                idx <= '0;
            end else if (state == S_CHK) begin
                idx <= idx + 1'b1;
            end
            // Ticks while sweeping are dropped; starting the sweep clears it.
            if (start_sweep) begin
                sweep_pend <= 1'b0;
            end else if (sweep_tick && !sweeping) begin
                sweep_pend <= 1'b1;
            end
        end
    end

`ifdef SEAT_ARB_STATS_EN
    always_ff @(posedge clk_arb or negedge rst_arb) begin
        if (!rst_arb) begin
            stat_reject <= '0;
            stat_expire <= '0;
        end else begin
            if ((state == R_CHK) && reject_d && (stat_reject != 16'hFFFF)) begin
                stat_reject <= stat_reject + 16'd1;
            end
            if (expire && (stat_expire != 16'hFFFF)) begin
                stat_expire <= stat_expire + 16'd1;
            end
        end
    end
`endif

endmodule
